step_scheduler: RTL and testbench

STEP_SCHEDULER -- requirements
Module: step_scheduler

---
 rtl/step_scheduler_pkg.sv | 31 +++
 rtl/step_scheduler_divider.sv | 79 +++++++
 rtl/step_scheduler.sv | 139 +++++++++++++
 tb/tb_step_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/step_scheduler_pkg.sv
// Shared types and constants for the step scheduler: one-hot FSM states,
// tempo clamp limits, divider width and the per-step interval helper.
package step_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_WAIT = 3'b010,
      ST_RUN  = 3'b100
   } state_t;

   localparam logic [9:0] BPM_MIN = 10'd20;
   localparam logic [9:0] BPM_MAX = 10'd300;
   localparam int         DVD_W   = 32;

   function automatic logic [9:0] clamp_bpm(input logic [9:0] bpm);
      if (bpm < BPM_MIN) return BPM_MIN;
      if (bpm > BPM_MAX) return BPM_MAX;
      return bpm;
   endfunction

   // Swing lengthens the interval after an even step and shortens the one after an odd step.
   function automatic logic [DVD_W-1:0] step_interval(input logic [DVD_W-1:0] period,
                                                      input logic             odd_step,
                                                      input logic             swing_on);
      logic [DVD_W-1:0] quarter;
      quarter = period >> 2;
      if (!swing_on) return period;
      return odd_step ? (period - quarter) : (period + quarter);
   endfunction

endpackage

// File: rtl/step_scheduler_divider.sv
// seq_divider: 32-bit restoring divider, one quotient bit per cycle.
// start is taken only while idle; done pulses for one cycle with the quotient valid.
module seq_divider
   import step_scheduler_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVD_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DVD_W-1:0] quotient
);
   localparam int              CNT_W    = $clog2(DVD_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DVD_W - 1);

   logic             active_q, active_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DVD_W-1:0] quo_q, quo_d;
   logic [DVD_W-1:0] rem_q, rem_d;
   logic [DVD_W-1:0] dvs_q, dvs_d;
   logic [DVD_W:0]   shifted;

   always_comb begin
      active_d = active_q;
      done_d   = 1'b0;
      cnt_d    = cnt_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      shifted  = {rem_q, quo_q[DVD_W-1]};
      if (active_q) begin
         // remainder < divisor, so the trial difference always fits in DVD_W bits
         if (shifted >= {1'b0, dvs_q}) begin
            rem_d = shifted[DVD_W-1:0] - dvs_q;
            quo_d = {quo_q[DVD_W-2:0], 1'b1};
         end else begin
            rem_d = shifted[DVD_W-1:0];
            quo_d = {quo_q[DVD_W-2:0], 1'b0};
         end
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) begin
            active_d = 1'b0;
            done_d   = 1'b1;
         end
      end else if (start && !done_q) begin
         active_d = 1'b1;
         cnt_d    = '0;
         quo_d    = dividend;
         rem_d    = '0;
         dvs_d    = divisor;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
      end else begin
         active_q <= active_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
      end
   end

   assign busy     = active_q | done_q;
   assign done     = done_q;
   assign quotient = quo_q;

endmodule

// File: rtl/step_scheduler.sv
// Step sequencer clock: derives the step period from BPM and emits step ticks/indices.
// Optional swing timing (swing port) is enabled with `define SWING_EN.
module step_scheduler
   import step_scheduler_pkg::*;
#(
   parameter int CLK_FREQ       = 50000000,
   parameter int STEPS_PER_BEAT = 4,
   parameter int NUM_STEPS      = 16
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] bpm,
   input  logic       play,
   input  logic       stop,
`ifdef SWING_EN
   input  logic       swing,
`endif
   output logic       step_tick,
   output logic [3:0] step_index,
   output logic       playing,
   output logic       busy
);
   localparam longint           DIVIDEND_L = (longint'(CLK_FREQ) * 64'd60) / longint'(STEPS_PER_BEAT);
   localparam logic [DVD_W-1:0] DIVIDEND   = DVD_W'(DIVIDEND_L);
   localparam logic [3:0]       LAST_IDX   = 4'(NUM_STEPS - 1);

   state_t           state_q, state_d;
   logic [3:0]       idx_q, idx_d, idx_next;
   logic [DVD_W-1:0] cnt_q, cnt_d;
   logic [DVD_W-1:0] intvl_q, intvl_d;
   logic [DVD_W-1:0] period_q, period_d;
   logic             period_vld_q, period_vld_d;
   logic             tick_q, tick_d;
   logic [9:0]       last_bpm_q, last_bpm_d;
   logic [9:0]       eff_bpm;
   logic             div_start, div_busy, div_done, enter_run, swing_on;
   logic [DVD_W-1:0] div_quo;

`ifdef SWING_EN
   assign swing_on = swing;
`else
   assign swing_on = 1'b0;
`endif

   seq_divider u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (DIVIDEND),
      .divisor  ({{(DVD_W-10){1'b0}}, eff_bpm}),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quo)
   );

   always_comb begin
      eff_bpm      = clamp_bpm(bpm);
      // last_bpm resets to 0, which no clamped tempo equals, so a division starts right after reset
      div_start    = !div_busy && (eff_bpm != last_bpm_q);
      last_bpm_d   = div_start ? eff_bpm : last_bpm_q;
      period_d     = div_done ? div_quo : period_q;
      period_vld_d = period_vld_q | div_done;
      idx_next     = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;

      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      intvl_d   = intvl_q;
      tick_d    = 1'b0;
      enter_run = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (play) begin
               if (period_vld_d) enter_run = 1'b1;
               else              state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (period_vld_d) enter_run = 1'b1;
         end
         ST_RUN: begin
            if (cnt_q == intvl_q - 1'b1) begin
               idx_d   = idx_next;
               tick_d  = 1'b1;
               cnt_d   = '0;
               intvl_d = step_interval(period_d, idx_next[0], swing_on);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (enter_run) begin
         state_d = ST_RUN;
         tick_d  = 1'b1;
         cnt_d   = '0;
         intvl_d = step_interval(period_d, idx_q[0], swing_on);
      end

      if (stop) begin
         state_d = ST_IDLE;
         idx_d   = 4'd0;
         cnt_d   = '0;
         tick_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= 4'd0;
         cnt_q        <= '0;
         intvl_q      <= '0;
         period_q     <= '0;
         period_vld_q <= 1'b0;
         tick_q       <= 1'b0;
         last_bpm_q   <= 10'd0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         intvl_q      <= intvl_d;
         period_q     <= period_d;
         period_vld_q <= period_vld_d;
         tick_q       <= tick_d;
         last_bpm_q   <= last_bpm_d;
      end
   end

   // A stop in the same cycle as a registered tick kills that tick.
   assign step_tick  = tick_q & ~stop;
   assign step_index = idx_q;
   assign playing    = (state_q != ST_IDLE);
   assign busy       = div_busy;

endmodule

// File: tb/tb_step_scheduler.sv
// Bench for step_scheduler: cycle-timed event model compared every cycle,
// plus directed tempo/play/stop scenarios with hand-computed interval checks.
module tb_step_scheduler;
   localparam longint DIVIDEND = 15000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] bpm = 10'd100;
   logic       play = 1'b0;
   logic       stop = 1'b0;
   logic       swing = 1'b0;
   logic       step_tick, playing, busy;
   logic [3:0] step_index;

   int     checks = 0;
   int     failures = 0;
   longint cyc = 0;
   longint tick_cyc[$];
   longint tick_idx[$];

   step_scheduler #(.CLK_FREQ(1000), .STEPS_PER_BEAT(4), .NUM_STEPS(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .bpm        (bpm),
      .play       (play),
      .stop       (stop),
`ifdef SWING_EN
      .swing      (swing),
`endif
      .step_tick  (step_tick),
      .step_index (step_index),
      .playing    (playing),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got cyc=%0d required finish", cyc);
      $fatal(1);
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d required %0d", nm, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model (absolute cycle times) ----------------
   longint m_last, m_div_bpm, m_done_cyc, m_period, m_idx, m_tick_cyc, m_next;
   bit     m_div_act, m_vld, m_run, m_wait;

   function automatic longint clampm(input longint b);
      return (b < 20) ? 20 : (b > 300) ? 300 : b;
   endfunction

   function automatic longint intv(input longint p, input longint idx, input bit sw);
      if (!sw) return p;
      return (idx % 2 == 0) ? p + p / 4 : p - p / 4;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         m_last = 0; m_div_bpm = 0; m_done_cyc = 0; m_period = 0; m_idx = 0;
         m_tick_cyc = -1; m_next = 0; m_div_act = 0; m_vld = 0; m_run = 0; m_wait = 0;
         chk("rst_tick", step_tick, 0);
         chk("rst_index", step_index, 0);
         chk("rst_playing", playing, 0);
         chk("rst_busy", busy, 0);
      end else begin
         longint eff, np;
         bit done_now, start_now, nv, sw, go;
         chk("tick", step_tick, ((m_tick_cyc == cyc) && !stop) ? 1 : 0);
         chk("index", step_index, m_idx);
         chk("playing", playing, (m_run || m_wait) ? 1 : 0);
         chk("busy", busy, m_div_act ? 1 : 0);
         if (step_tick) begin
            tick_cyc.push_back(cyc);
            tick_idx.push_back(longint'(step_index));
         end
`ifdef SWING_EN
         sw = swing;
`else
         sw = 1'b0;
`endif
         eff       = clampm(longint'(bpm));
         done_now  = m_div_act && (cyc == m_done_cyc);
         nv        = m_vld || done_now;
         np        = done_now ? DIVIDEND / m_div_bpm : m_period;
         start_now = !m_div_act && (eff != m_last);
         if (done_now) m_div_act = 0;
         if (start_now) begin
            m_div_act = 1; m_done_cyc = cyc + 33; m_last = eff; m_div_bpm = eff;
         end
         m_vld = nv; m_period = np;
         go = 0;
         if (stop) begin
            m_run = 0; m_wait = 0; m_idx = 0;
         end else if (!m_run && !m_wait && play) begin
            if (nv) go = 1; else m_wait = 1;
         end else if (m_wait && nv) begin
            go = 1;
         end else if (m_run && (cyc + 1 == m_next)) begin
            m_idx = (m_idx + 1) % 16;
            m_tick_cyc = cyc + 1;
            m_next = cyc + 1 + intv(np, m_idx, sw);
         end
         if (go) begin
            m_run = 1; m_wait = 0;
            m_tick_cyc = cyc + 1;
            m_next = cyc + 1 + intv(np, m_idx, sw);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_play();
      play = 1'b1; step(1); play = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; step(1); stop = 1'b0;
   endtask

   task automatic wait_ticks(input int need, input int budget, output bit ok);
      int n = 0;
      while (tick_cyc.size() < need && n < budget) begin
         step(1);
         n++;
      end
      ok = (tick_cyc.size() >= need);
      if (!ok) chk("tick_timeout", tick_cyc.size(), need);
   endtask

   initial begin
      int b, nbusy;
      longint rel, pc;
      bit ok;

      // reset, first division, then play at BPM=100
      step(3);
      rst = 1'b0;
      nbusy = 0;
      for (int i = 0; i < 60; i++) begin
         step(1);
         if (busy) nbusy++;
         else if (nbusy > 0) break;
      end
      chk("busy_len", nbusy, 33);
      b = tick_cyc.size();
      pc = cyc;
      pulse_play();
      wait_ticks(b + 17, 17 * 150 + 20, ok);
      if (ok) begin
         chk("first_tick_delay", tick_cyc[b] - pc, 1);
         chk("first_tick_idx", tick_idx[b], 0);
         chk("interval_100", tick_cyc[b+1] - tick_cyc[b], 150);
         chk("idx_tick2", tick_idx[b+1], 1);
         chk("idx_tick16", tick_idx[b+15], 15);
         chk("idx_wrap", tick_idx[b+16], 0);
         chk("interval_wrap", tick_cyc[b+16] - tick_cyc[b+15], 150);
      end

      // tempo change mid-interval: current interval kept, then new period
      b = tick_cyc.size();
      wait_ticks(b + 1, 200, ok);
      step(5);
      bpm = 10'd150;
      wait_ticks(b + 4, 500, ok);
      if (ok) begin
         chk("retime_keep", tick_cyc[b+1] - tick_cyc[b], 150);
         chk("retime_new1", tick_cyc[b+2] - tick_cyc[b+1], 100);
         chk("retime_new2", tick_cyc[b+3] - tick_cyc[b+2], 100);
      end

      // play+stop together exactly on a tick cycle
      b = tick_cyc.size();
      wait_ticks(b + 1, 200, ok);
      step(99);
      play = 1'b1; stop = 1'b1;
      @(negedge clk);
      chk("stop_kills_tick", step_tick, 0);
      step(1);
      play = 1'b0; stop = 1'b0;
      chk("stop_playing", playing, 0);
      chk("stop_index", step_index, 0);
      chk("stop_no_log", tick_cyc.size(), b + 1);

      // clamp low: BPM=5 -> 20
      bpm = 10'd5;
      step(40);
      b = tick_cyc.size();
      pulse_play();
      wait_ticks(b + 2, 1700, ok);
      if (ok) begin
         chk("clamp_low_period", tick_cyc[b+1] - tick_cyc[b], 750);
         chk("clamp_low_idx0", tick_idx[b], 0);
      end
      pulse_stop();

      // clamp high: BPM=999 -> 300
      bpm = 10'd999;
      step(40);
      b = tick_cyc.size();
      pulse_play();
      wait_ticks(b + 2, 200, ok);
      if (ok) chk("clamp_high_period", tick_cyc[b+1] - tick_cyc[b], 50);
      pulse_stop();

`ifdef SWING_EN
      bpm = 10'd100;
      swing = 1'b1;
      step(40);
      b = tick_cyc.size();
      pulse_play();
      wait_ticks(b + 3, 600, ok);
      if (ok) begin
         chk("swing_even", tick_cyc[b+1] - tick_cyc[b], 187);
         chk("swing_odd", tick_cyc[b+2] - tick_cyc[b+1], 113);
      end
      swing = 1'b0;
      pulse_stop();
`endif

      // play one cycle after reset release -> WAIT, tick when period becomes valid
      bpm = 10'd100;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      rel = cyc;
      b = tick_cyc.size();
      step(1);
      play = 1'b1;
      chk("wait_busy", busy, 1);
      step(1);
      play = 1'b0;
      chk("wait_playing", playing, 1);
      wait_ticks(b + 1, 60, ok);
      if (ok) begin
         chk("wait_first_tick", tick_cyc[b] - rel, 34);
         chk("wait_first_idx", tick_idx[b], 0);
      end
      pulse_stop();
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
